// File: rtl/alu_reservation_station.sv
// alu_reservation_station: Tomasulo RS that snoops both CDBs and launches one ready op per cycle into the ALU.
// Define RS_PERF_EN to add the perf_dispatch_cnt / perf_full_cycles counters.
module alu_reservation_station #(
  parameter int RS_ENTRIES = 8,
  parameter int ROB_W = 4,
  parameter int OPT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             issue_valid,
  input  logic [OPT_W-1:0] issue_opt,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qj_busy,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_pc,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_value,
  output logic             alu_en,
  output logic [OPT_W-1:0] alu_opt,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob
`ifdef RS_PERF_EN
  ,
  output logic [31:0]      perf_dispatch_cnt,
  output logic [31:0]      perf_full_cycles
`endif
);
  localparam int IW = $clog2(RS_ENTRIES);
  logic [RS_ENTRIES-1:0] busy, qj_busy, qk_busy, ready;
  logic [OPT_W-1:0] opt [RS_ENTRIES];
  logic [31:0] vj [RS_ENTRIES];
  logic [31:0] vk [RS_ENTRIES];
  logic [31:0] imm [RS_ENTRIES];
  logic [31:0] pc [RS_ENTRIES];
  logic [ROB_W-1:0] qj [RS_ENTRIES];
  logic [ROB_W-1:0] qk [RS_ENTRIES];
  logic [ROB_W-1:0] rob [RS_ENTRIES];
  logic [IW-1:0] free_idx, sel_idx;
  logic sel_ok, aj, lj, ak, lk, in_qjb, in_qkb;
  logic [31:0] in_vj, in_vk;
  assign rs_full = &busy;
  assign ready = busy & ~qj_busy & ~qk_busy;
  assign sel_ok = |ready;
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
      if (ready[i]) sel_idx = IW'(i);
    end
  end
  // Same-cycle bypass of the issuing operands; ALU bus wins over LSB bus.
  assign aj = alu_cdb_valid && alu_cdb_rob == issue_qj;
  assign lj = lsb_cdb_valid && lsb_cdb_rob == issue_qj;
  assign ak = alu_cdb_valid && alu_cdb_rob == issue_qk;
  assign lk = lsb_cdb_valid && lsb_cdb_rob == issue_qk;
  assign in_qjb = issue_qj_busy && !aj && !lj;
  assign in_qkb = issue_qk_busy && !ak && !lk;
  assign in_vj = !issue_qj_busy ? issue_vj : aj ? alu_cdb_value : lj ? lsb_cdb_value : issue_vj;
  assign in_vk = !issue_qk_busy ? issue_vk : ak ? alu_cdb_value : lk ? lsb_cdb_value : issue_vk;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      alu_en <= 1'b0;
      alu_opt <= '0;
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_imm <= '0;
      alu_pc <= '0;
      alu_rob <= '0;
`ifdef RS_PERF_EN
      perf_dispatch_cnt <= '0;
      perf_full_cycles <= '0;
`endif
    end else if (flush_in) begin
      busy <= '0;
      alu_en <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (alu_cdb_valid && alu_cdb_rob == qj[i]) begin
            vj[i] <= alu_cdb_value;
            qj_busy[i] <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob == qj[i]) begin
            vj[i] <= lsb_cdb_value;
            qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_busy[i]) begin
          if (alu_cdb_valid && alu_cdb_rob == qk[i]) begin
            vk[i] <= alu_cdb_value;
            qk_busy[i] <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_rob == qk[i]) begin
            vk[i] <= lsb_cdb_value;
            qk_busy[i] <= 1'b0;
          end
        end
      end
      alu_en <= sel_ok;
      if (sel_ok) begin
        alu_opt <= opt[sel_idx];
        alu_rs1 <= vj[sel_idx];
        alu_rs2 <= vk[sel_idx];
        alu_imm <= imm[sel_idx];
        alu_pc <= pc[sel_idx];
        alu_rob <= rob[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      // free_idx is never sel_idx: one is idle, the other busy.
      if (issue_valid && !rs_full) begin
        busy[free_idx] <= 1'b1;
        opt[free_idx] <= issue_opt;
        vj[free_idx] <= in_vj;
        vk[free_idx] <= in_vk;
        qj_busy[free_idx] <= in_qjb;
        qk_busy[free_idx] <= in_qkb;
        qj[free_idx] <= issue_qj;
        qk[free_idx] <= issue_qk;
        imm[free_idx] <= issue_imm;
        pc[free_idx] <= issue_pc;
        rob[free_idx] <= issue_rob;
      end
`ifdef RS_PERF_EN
      perf_dispatch_cnt <= perf_dispatch_cnt + 32'(sel_ok);
      perf_full_cycles <= perf_full_cycles + 32'(rs_full);
`endif
    end
  end
endmodule
